response_uart_tx: RTL and testbench

// - Transmit end of the response-word interface: accepts one 32-bit response word
//   (up to 4 ASCII bytes) plus its byte count, and serialises it onto the UART TX line.
// - Drives busy_sender_data back to the controller.
// - Sits between the command/IO controller and the board UART TX pin, with an

---
 rtl/response_uart_tx_pkg.sv | 16 +
 rtl/response_uart_tx_byte.sv | 91 +++++++++
 rtl/response_uart_tx.sv | 99 +++++++++
 tb/tb_response_uart_tx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/response_uart_tx_pkg.sv
// Shared constants and FSM state type for the response-word UART transmitter.
package response_uart_tx_pkg;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} tx_state_e;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int unsigned bytes_per_word(input int unsigned word_size,
                                                 input int unsigned data_width);
    return word_size / data_width;
  endfunction

endpackage

// File: rtl/response_uart_tx_byte.sv
// 8N1 bit serialiser: one start bit, DATA_WIDTH data bits LSB first, one stop bit.
// A start on the final stop-bit cycle (done) chains the next byte with no idle gap.
module response_uart_tx_byte
  import response_uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  tx_state_e             state_q;
  logic [BaudW-1:0]      baud_q;
  logic [BitW-1:0]       bit_idx_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  tx_q;
  logic                  baud_last;

  assign baud_last = (baud_q == BaudW'(CLKS_PER_BIT - 1));
  assign done      = (state_q == StStop) && baud_last;
  assign busy      = (state_q != StIdle);
  assign tx        = tx_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else if (start && ((state_q == StIdle) || done)) begin
      state_q   <= StStart;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= data;
      tx_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          baud_q <= '0;
          tx_q   <= 1'b1;
        end
        StStart: begin
          if (baud_last) begin
            baud_q  <= '0;
            state_q <= StData;
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
          end else begin
            baud_q <= baud_q + BaudW'(1);
          end
        end
        StData: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_idx_q == BitW'(DATA_WIDTH - 1)) begin
              bit_idx_q <= '0;
              state_q   <= StStop;
              tx_q      <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + BitW'(1);
              tx_q      <= shift_q[0];
              shift_q   <= shift_q >> 1;
            end
          end else begin
            baud_q <= baud_q + BaudW'(1);
          end
        end
        StStop: begin
          if (baud_last) begin
            baud_q  <= '0;
            state_q <= StIdle;
            tx_q    <= 1'b1;
          end else begin
            baud_q <= baud_q + BaudW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/response_uart_tx.sv
// Response-word UART transmitter: latches a word plus byte count and sends the bytes
// LSB-byte first through the 8N1 serialiser, reporting busy and an end-of-frame pulse.
module response_uart_tx
  import response_uart_tx_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = 32,
  parameter int unsigned SIZE_WORD  = 3,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned BAUD_RATE  = 115200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] send_data_register,
  input  logic [SIZE_WORD-1:0] size_line,
  input  logic                 valid_data,
  output logic                 busy_sender_data,
  output logic                 tx,
  output logic                 frame_done
);

  localparam int unsigned ClksPerBit = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int unsigned Bpw        = bytes_per_word(WORD_SIZE, DATA_WIDTH);
  localparam int unsigned IdxW       = (Bpw > 1) ? $clog2(Bpw) : 1;

  logic                  busy_q;
  logic                  frame_done_q;
  logic                  armed_q;
  logic [WORD_SIZE-1:0]  word_q;
  logic [IdxW-1:0]       byte_idx_q;
  logic [IdxW-1:0]       last_idx_q;
  logic [IdxW-1:0]       clamped_last;
  logic                  idle;
  logic                  accept;
  logic                  next_byte;
  logic                  byte_start;
  logic [DATA_WIDTH-1:0] byte_data;
  logic                  byte_busy;
  logic                  byte_done;

  assign idle       = !busy_q && !byte_busy;
  assign accept     = idle && armed_q && valid_data && (size_line != '0);
  assign next_byte  = busy_q && byte_done && (byte_idx_q != last_idx_q);
  assign byte_start = accept || next_byte;
  // word_q holds only the bytes not yet handed to the serialiser, low byte next.
  assign byte_data  = accept ? send_data_register[DATA_WIDTH-1:0] : word_q[DATA_WIDTH-1:0];

  always_comb begin
    if (32'(size_line) > Bpw) clamped_last = IdxW'(Bpw - 1);
    else                      clamped_last = IdxW'(32'(size_line) - 1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      armed_q      <= 1'b1;
      word_q       <= '0;
      byte_idx_q   <= '0;
      last_idx_q   <= '0;
    end else begin
      frame_done_q <= 1'b0;
      // A held request is consumed once; it must drop before another frame starts.
      if (!valid_data)                   armed_q <= 1'b1;
      else if (idle && armed_q)          armed_q <= 1'b0;
      if (accept) begin
        busy_q     <= 1'b1;
        word_q     <= send_data_register >> DATA_WIDTH;
        byte_idx_q <= '0;
        last_idx_q <= clamped_last;
      end else if (busy_q && byte_done) begin
        if (byte_idx_q == last_idx_q) begin
          busy_q       <= 1'b0;
          frame_done_q <= 1'b1;
        end else begin
          byte_idx_q <= byte_idx_q + IdxW'(1);
          word_q     <= word_q >> DATA_WIDTH;
        end
      end
    end
  end

  response_uart_tx_byte #(
    .DATA_WIDTH  (DATA_WIDTH),
    .CLKS_PER_BIT(ClksPerBit)
  ) u_byte (
    .clk  (clk),
    .rst  (rst),
    .start(byte_start),
    .data (byte_data),
    .tx   (tx),
    .busy (byte_busy),
    .done (byte_done)
  );

  assign busy_sender_data = busy_q;
  assign frame_done       = frame_done_q;

endmodule

// File: tb/tb_response_uart_tx.sv
// Directed bench for response_uart_tx at 16 clocks per bit: decodes tx line captures
// and checks bytes, framing, busy length, end-of-frame pulse, re-arm and abort.
module tb_response_uart_tx;

  localparam int BitCyc  = 16;
  localparam int ByteCyc = 10 * BitCyc;
  localparam int LogLen  = 1200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] send_data_register = '0;
  logic [2:0]  size_line = '0;
  logic        valid_data = 1'b0;
  logic        busy_sender_data;
  logic        tx;
  logic        frame_done;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic tx_log [0:LogLen-1];
  int   busy_cnt, done_cnt, done_at;

  response_uart_tx #(
    .WORD_SIZE (32),
    .SIZE_WORD (3),
    .DATA_WIDTH(8),
    .CLK_FREQ  (16),
    .BAUD_RATE (1)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .send_data_register(send_data_register),
    .size_line         (size_line),
    .valid_data        (valid_data),
    .busy_sender_data  (busy_sender_data),
    .tx                (tx),
    .frame_done        (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rx_byte(input int k);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) r[b] = tx_log[k * ByteCyc + (b + 1) * BitCyc + BitCyc / 2];
    return r;
  endfunction

  function automatic bit frame_ok(input int k);
    return (tx_log[k * ByteCyc + BitCyc / 2] === 1'b0) &&
           (tx_log[k * ByteCyc + 9 * BitCyc + BitCyc / 2] === 1'b1);
  endfunction

  function automatic int zeros(input int from, input int to);
    int z = 0;
    for (int i = from; i < to; i++) if (tx_log[i] !== 1'b1) z++;
    return z;
  endfunction

  task automatic start_frame(input logic [31:0] word, input logic [2:0] size);
    @(negedge clk);
    send_data_register = word;
    size_line          = size;
    valid_data         = 1'b1;
  endtask

  // Sample n cycles after the accepting edge; drop valid after hold cycles and optionally
  // inject a one-cycle request with a different word while the frame is in flight.
  task automatic capture(input int n, input int hold, input int pulse_at);
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = -1;
    @(posedge clk);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tx_log[i] = tx;
      if (busy_sender_data === 1'b1) busy_cnt++;
      if (frame_done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
      if (i == hold - 1) valid_data = 1'b0;
      if (i == pulse_at) begin
        valid_data         = 1'b1;
        send_data_register = 32'hFFFF_FFFF;
        size_line          = 3'd1;
      end
      if (i == pulse_at + 1) valid_data = 1'b0;
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
    n_checks++; if (busy_sender_data !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b want 0", busy_sender_data); end
    n_checks++; if (frame_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_done: got %b want 0", frame_done); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_checks++; if (tx !== 1'b1 || busy_sender_data !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_reset: got tx=%b busy=%b done=%b want 1 0 0",
               tx, busy_sender_data, frame_done);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_full_word();
    logic [7:0] exp [4] = '{8'h4F, 8'h4B, 8'h0A, 8'h0D};
    start_frame(32'h0D0A4B4F, 3'd4);
    capture(700, 1, -1);
    n_checks++; if (tx_log[0] !== 1'b0) begin
      n_fail++; $display("FAIL full_first_start: got %b want 0", tx_log[0]); end
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (rx_byte(k) !== exp[k]) begin
        n_fail++; $display("FAIL full_byte%0d: got %h want %h", k, rx_byte(k), exp[k]); end
      n_checks++; if (!frame_ok(k)) begin
        n_fail++; $display("FAIL full_framing%0d: got bad start/stop want 0/1", k); end
    end
    n_checks++; if (busy_cnt != 640) begin
      n_fail++; $display("FAIL full_busy_len: got %0d want 640", busy_cnt); end
    n_checks++; if (done_cnt != 1 || done_at != 640) begin
      n_fail++; $display("FAIL full_done: got %0d pulses at %0d want 1 at 640", done_cnt, done_at);
    end
    n_checks++; if (zeros(640, 700) != 0) begin
      n_fail++; $display("FAIL full_tail_idle: got %0d low cycles want 0", zeros(640, 700)); end
  endtask

  task automatic test_short_word();
    start_frame(32'h0D0A2031, 3'd2);
    capture(420, 1, -1);
    n_checks++; if (rx_byte(0) !== 8'h31 || rx_byte(1) !== 8'h20) begin
      n_fail++; $display("FAIL short_bytes: got %h %h want 31 20", rx_byte(0), rx_byte(1)); end
    n_checks++; if (busy_cnt != 320) begin
      n_fail++; $display("FAIL short_busy_len: got %0d want 320", busy_cnt); end
    n_checks++; if (done_cnt != 1 || done_at != 320) begin
      n_fail++; $display("FAIL short_done: got %0d at %0d want 1 at 320", done_cnt, done_at); end
    n_checks++; if (zeros(320, 420) != 0) begin
      n_fail++; $display("FAIL short_no_extra: got %0d low cycles want 0", zeros(320, 420)); end
  endtask

  task automatic test_level_hold();
    logic [7:0] exp [4] = '{8'h42, 8'h53, 8'h59, 8'h0D};
    start_frame(32'h0D595342, 3'd4);
    capture(1000, 1000, -1);
    n_checks++; if (busy_cnt != 640 || done_cnt != 1) begin
      n_fail++; $display("FAIL hold_single_frame: got busy=%0d pulses=%0d want 640 1",
                         busy_cnt, done_cnt);
    end
    n_checks++; if (zeros(640, 1000) != 0) begin
      n_fail++; $display("FAIL hold_no_refire: got %0d low cycles want 0", zeros(640, 1000)); end
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (rx_byte(k) !== exp[k]) begin
        n_fail++; $display("FAIL hold_byte%0d: got %h want %h", k, rx_byte(k), exp[k]); end
    end
    start_frame(32'h0D595342, 3'd4);
    capture(700, 1, -1);
    n_checks++; if (tx_log[0] !== 1'b0 || busy_cnt != 640) begin
      n_fail++; $display("FAIL hold_rearm: got start=%b busy=%0d want 0 640", tx_log[0], busy_cnt);
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (rx_byte(k) !== exp[k] || !frame_ok(k)) begin
        n_fail++; $display("FAIL hold2_byte%0d: got %h want %h", k, rx_byte(k), exp[k]); end
    end
  endtask

  task automatic test_bounds();
    logic [7:0] exp [4] = '{8'h41, 8'h42, 8'h43, 8'h44};
    start_frame(32'h12345678, 3'd0);
    capture(200, 1, -1);
    n_checks++; if (busy_cnt != 0 || done_cnt != 0) begin
      n_fail++; $display("FAIL zero_size_busy: got busy=%0d pulses=%0d want 0 0", busy_cnt, done_cnt);
    end
    n_checks++; if (zeros(0, 200) != 0) begin
      n_fail++; $display("FAIL zero_size_tx: got %0d low cycles want 0", zeros(0, 200)); end
    start_frame(32'h44434241, 3'd7);
    capture(700, 1, -1);
    n_checks++; if (busy_cnt != 640 || done_at != 640) begin
      n_fail++; $display("FAIL clamp_len: got busy=%0d done_at=%0d want 640 640", busy_cnt, done_at);
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (rx_byte(k) !== exp[k]) begin
        n_fail++; $display("FAIL clamp_byte%0d: got %h want %h", k, rx_byte(k), exp[k]); end
    end
    start_frame(32'h000000A5, 3'd1);
    capture(400, 1, 50);
    n_checks++; if (rx_byte(0) !== 8'hA5 || !frame_ok(0)) begin
      n_fail++; $display("FAIL busy_ignore_byte: got %h want a5", rx_byte(0)); end
    n_checks++; if (busy_cnt != 160 || done_cnt != 1) begin
      n_fail++; $display("FAIL busy_ignore_len: got busy=%0d pulses=%0d want 160 1",
                         busy_cnt, done_cnt);
    end
    n_checks++; if (zeros(160, 400) != 0) begin
      n_fail++; $display("FAIL busy_ignore_queue: got %0d low cycles want 0", zeros(160, 400)); end
  endtask

  task automatic test_abort();
    logic [7:0] exp [4] = '{8'h4F, 8'h4B, 8'h0A, 8'h0D};
    int bad = 0;
    start_frame(32'h0D0A4B4F, 3'd4);
    @(posedge clk);
    // Stop in the middle of data bit 3 of byte index 2.
    for (int i = 0; i <= 2 * ByteCyc + 4 * BitCyc + BitCyc / 2; i++) begin
      @(negedge clk);
      if (i == 0) valid_data = 1'b0;
    end
    n_checks++; if (busy_sender_data !== 1'b1) begin
      n_fail++; $display("FAIL abort_pre_busy: got %b want 1", busy_sender_data); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (tx !== 1'b1 || busy_sender_data !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++; $display("FAIL abort_immediate: got tx=%b busy=%b done=%b want 1 0 0",
                         tx, busy_sender_data, frame_done);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy_sender_data !== 1'b0 || frame_done !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin
      n_fail++; $display("FAIL abort_no_resume: got %0d active cycles want 0", bad); end
    start_frame(32'h0D0A4B4F, 3'd4);
    capture(700, 1, -1);
    n_checks++; if (busy_cnt != 640 || done_at != 640) begin
      n_fail++; $display("FAIL abort_next_len: got busy=%0d done_at=%0d want 640 640",
                         busy_cnt, done_at);
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (rx_byte(k) !== exp[k] || !frame_ok(k)) begin
        n_fail++; $display("FAIL abort_next_byte%0d: got %h want %h", k, rx_byte(k), exp[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_short_word();
    test_level_hold();
    test_bounds();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
